datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 33 +++
 tb/tb_datapath.sv | 98 +++++++++
 2 files changed

// File: rtl/datapath.sv
// datapath: elevator request latch, one-hot floor position and request-direction flags
module datapath #(
  parameter int n = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         open,
  input  logic         up,
  input  logic         down,
  input  logic [n-1:0] button_out,
  input  logic [n-1:0] button_in,
  output logic         request_i,
  output logic         request_j_gt_i,
  output logic         request_j_lt_i,
  output logic [n-1:0] i
);
  logic [n-1:0] req;
  logic [n-1:0] below;
  always_ff @(posedge clk) begin
    if (rst) begin
      req <= '0;
      i   <= {{(n-1){1'b0}}, 1'b1};
    end else begin
      req <= (req | ~button_out | ~button_in) & ~(open ? i : '0);
      i   <= (up && !down && !i[n-1]) ? i << 1 :
             (down && !up && !i[0])   ? i >> 1 : i;
    end
  end
  assign below          = i - 1'b1;
  assign request_i      = |(req & i);
  assign request_j_gt_i = |(req & ~(i | below));
  assign request_j_lt_i = |(req & below);
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed and random stimulus against a floor/request reference model
module tb_datapath;
  localparam int N = 5;
  logic         clk = 1'b0;
  logic         rst, open, up, down;
  logic [N-1:0] button_out, button_in;
  logic         request_i, request_j_gt_i, request_j_lt_i;
  logic [N-1:0] i;
  int           vectors = 0;
  int           miscompares = 0;
  int           pos;
  bit           mreq [N];
  datapath #(.n(N)) dut (
    .clk(clk), .rst(rst), .open(open), .up(up), .down(down),
    .button_out(button_out), .button_in(button_in),
    .request_i(request_i), .request_j_gt_i(request_j_gt_i),
    .request_j_lt_i(request_j_lt_i), .i(i)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge(input bit r, input bit o, input bit u, input bit d,
                            input logic [N-1:0] bo, input logic [N-1:0] bi);
    if (r) begin
      foreach (mreq[k]) mreq[k] = 1'b0;
      pos = 0;
      return;
    end
    for (int k = 0; k < N; k++) if (!bo[k] || !bi[k]) mreq[k] = 1'b1;
    if (o) mreq[pos] = 1'b0;
    if (u && !d && pos < N - 1) pos++;
    else if (d && !u && pos > 0) pos--;
  endtask
  task automatic step(input bit r, input bit o, input bit u, input bit d,
                      input logic [N-1:0] bo, input logic [N-1:0] bi);
    bit here, gt, lt;
    rst = r; open = o; up = u; down = d; button_out = bo; button_in = bi;
    @(posedge clk);
    model_edge(r, o, u, d, bo, bi);
    #1;
    here = mreq[pos];
    gt = 1'b0;
    lt = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k > pos && mreq[k]) gt = 1'b1;
      if (k < pos && mreq[k]) lt = 1'b1;
    end
    check("floor", 32'(i), 32'(1) << pos);
    check("request_i", 32'(request_i), 32'(here));
    check("request_gt", 32'(request_j_gt_i), 32'(gt));
    check("request_lt", 32'(request_j_lt_i), 32'(lt));
  endtask
  initial begin
    logic [N-1:0] ones;
    ones = '1;
    pos = 0;
    foreach (mreq[k]) mreq[k] = 1'b0;
    step(1, 0, 0, 0, ones, ones);
    check("reset_floor0", 32'(i), 32'd1);
    step(0, 0, 0, 0, 5'b11010, ones);
    step(0, 1, 0, 0, ones, ones);
    step(0, 0, 1, 0, ones, ones);
    check("up_floor1", 32'(i), 32'b00010);
    step(0, 0, 1, 0, ones, ones);
    check("up_floor2", 32'(i), 32'b00100);
    check("serve_pending", 32'(request_i), 32'd1);
    step(0, 1, 0, 0, ones, ones);
    check("all_served", 32'({request_i, request_j_gt_i, request_j_lt_i}), 32'd0);
    repeat (2) step(0, 0, 1, 0, ones, ones);
    repeat (3) step(0, 0, 1, 0, ones, ones);
    check("top_hold", 32'(i), 32'b10000);
    repeat (2) step(0, 0, 1, 1, ones, ones);
    check("both_hold", 32'(i), 32'b10000);
    repeat (4) step(0, 0, 0, 1, ones, ones);
    repeat (3) step(0, 0, 0, 1, ones, ones);
    check("bottom_hold", 32'(i), 32'b00001);
    repeat (2) step(0, 0, 1, 0, ones, ones);
    step(0, 1, 0, 0, ones, 5'b11011);
    check("clear_wins", 32'(request_i), 32'd0);
    step(0, 0, 0, 0, 5'b01110, ones);
    check("both_dirs", 32'({request_j_gt_i, request_j_lt_i}), 32'b11);
    step(0, 0, 1, 0, ones, ones);
    step(1, 0, 1, 0, 5'b00000, 5'b00000);
    check("reset_discard", 32'({request_i, request_j_gt_i, request_j_lt_i}), 32'd0);
    for (int t = 0; t < 400; t++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom), 1'($urandom),
           N'($urandom | $urandom | $urandom), N'($urandom | $urandom | $urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
